axil_master: RTL and testbench

AXI4-Lite initiator that converts a simple single-outstanding command/response stream into AXI4-Lite write and read transactions. It sits between on-chip control logic or a test sequencer and memory-mapped AXI4-Lite register slaves such as the adder block, and drives their `s1_axi_*` slave ports directly. Exactly one transaction is in flight at a time. An optional watchdog flags transactions that stall.

---
 rtl/axil_master.sv | 179 +++++++++++++++++
 tb/tb_axil_master.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator: turns a cmd/rsp stream into AXI4-Lite
// write and read transactions, with an optional sticky stall watchdog.
module axil_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    timeout,
  input  logic                    timeout_clr,
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic [1:0]              m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic [1:0]              m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB        = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << LSB) - 1);

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    rst_done;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              resp_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    cmd_hs;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    ar_hs;

  // rst_done keeps cmd_ready low while reset is held, even though state is IDLE.
  assign cmd_ready      = (state == IDLE) && rst_done;
  assign cmd_hs         = cmd_valid && cmd_ready;
  assign m1_axi_awvalid = (state == WR) && !aw_done;
  assign m1_axi_wvalid  = (state == WR) && !w_done;
  assign m1_axi_bready  = (state == WB);
  assign m1_axi_arvalid = (state == RA);
  assign m1_axi_rready  = (state == RD);
  assign rsp_valid      = (state == RSP);
  assign aw_hs          = m1_axi_awvalid && m1_axi_awready;
  assign w_hs           = m1_axi_wvalid && m1_axi_wready;
  assign ar_hs          = m1_axi_arvalid && m1_axi_arready;

  assign m1_axi_awaddr  = addr_q;
  assign m1_axi_araddr  = addr_q;
  assign m1_axi_wdata   = wdata_q;
  assign m1_axi_wstrb   = wstrb_q;
  assign rsp_write      = write_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_resp       = resp_q;

  always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
    if (!m1_axi_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cmd_hs) state_next = cmd_write ? WR : RA;
      WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WB;
      WB:      if (m1_axi_bvalid) state_next = RSP;
      RA:      if (ar_hs) state_next = RD;
      RD:      if (m1_axi_rvalid) state_next = RSP;
      RSP:     if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
    if (!m1_axi_aresetn) begin
      rst_done <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      resp_q   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (cmd_hs) begin
        addr_q  <= cmd_addr & ADDR_MASK;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        write_q <= cmd_write;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if ((state == WB) && m1_axi_bvalid) begin
        resp_q  <= m1_axi_bresp;
        rdata_q <= '0;
      end
      if ((state == RD) && m1_axi_rvalid) begin
        resp_q  <= m1_axi_rresp;
        rdata_q <= m1_axi_rdata;
      end
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] wait_cnt;
      logic          bus_wait;
      logic          entering;
      logic          fire;

      assign bus_wait = (state == WR) || (state == WB) || (state == RA) || (state == RD);
      assign entering = (state_next != state) &&
                        ((state_next == WR) || (state_next == WB) ||
                         (state_next == RA) || (state_next == RD));
      assign fire     = bus_wait && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

      // Counter saturates so the flag fires once per phase; the bus keeps waiting.
      always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
          wait_cnt <= '0;
          timeout  <= 1'b0;
        end else begin
          if (entering) begin
            wait_cnt <= '0;
          end else if (bus_wait && (wait_cnt != CW'(TIMEOUT_CYCLES))) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          if (fire) begin
            timeout <= 1'b1;
          end else if (timeout_clr) begin
            timeout <= 1'b0;
          end
        end
      end
    end else begin : g_no_wdog
      logic unused_timeout_clr;
      assign unused_timeout_clr = timeout_clr;
      assign timeout = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: a delay-configurable AXI4-Lite slave model
// plus a response scoreboard filled when each command is issued.
module tb_axil_master;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 8;

  typedef struct {
    logic          write;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } rsp_t;

  logic            m1_axi_aclk = 1'b0;
  logic            m1_axi_aresetn;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_write;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            timeout;
  logic            timeout_clr;
  logic [AW-1:0]   m1_axi_awaddr;
  logic            m1_axi_awvalid;
  logic            m1_axi_awready;
  logic [DW-1:0]   m1_axi_wdata;
  logic [DW/8-1:0] m1_axi_wstrb;
  logic            m1_axi_wvalid;
  logic            m1_axi_wready;
  logic [1:0]      m1_axi_bresp;
  logic            m1_axi_bvalid;
  logic            m1_axi_bready;
  logic [AW-1:0]   m1_axi_araddr;
  logic            m1_axi_arvalid;
  logic            m1_axi_arready;
  logic [DW-1:0]   m1_axi_rdata;
  logic [1:0]      m1_axi_rresp;
  logic            m1_axi_rvalid;
  logic            m1_axi_rready;

  int            checks = 0;
  int            errors = 0;
  rsp_t          sb[$];
  int            aw_delay = 0;
  int            w_delay = 0;
  int            b_delay = 0;
  int            ar_delay = 0;
  int            r_delay = 0;
  logic [1:0]    bresp_cfg = 2'b00;
  logic [1:0]    rresp_cfg = 2'b00;
  logic [DW-1:0] rdata_cfg = '0;

  axil_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .m1_axi_aclk(m1_axi_aclk), .m1_axi_aresetn(m1_axi_aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .timeout(timeout), .timeout_clr(timeout_clr),
    .m1_axi_awaddr(m1_axi_awaddr), .m1_axi_awvalid(m1_axi_awvalid), .m1_axi_awready(m1_axi_awready),
    .m1_axi_wdata(m1_axi_wdata), .m1_axi_wstrb(m1_axi_wstrb), .m1_axi_wvalid(m1_axi_wvalid),
    .m1_axi_wready(m1_axi_wready),
    .m1_axi_bresp(m1_axi_bresp), .m1_axi_bvalid(m1_axi_bvalid), .m1_axi_bready(m1_axi_bready),
    .m1_axi_araddr(m1_axi_araddr), .m1_axi_arvalid(m1_axi_arvalid), .m1_axi_arready(m1_axi_arready),
    .m1_axi_rdata(m1_axi_rdata), .m1_axi_rresp(m1_axi_rresp), .m1_axi_rvalid(m1_axi_rvalid),
    .m1_axi_rready(m1_axi_rready)
  );

  always #5 m1_axi_aclk = ~m1_axi_aclk;

  // Slave model: each channel answers after its configured number of wait cycles.
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    m1_axi_awready = 1'b0; m1_axi_wready = 1'b0; m1_axi_arready = 1'b0;
    m1_axi_bvalid = 1'b0; m1_axi_bresp = 2'b00;
    m1_axi_rvalid = 1'b0; m1_axi_rresp = 2'b00; m1_axi_rdata = '0;
    forever begin
      @(negedge m1_axi_aclk);
      if (m1_axi_awvalid) begin
        m1_axi_awready = (aw_cnt == aw_delay);
        if (aw_cnt != aw_delay) aw_cnt++;
      end else begin
        m1_axi_awready = 1'b0; aw_cnt = 0;
      end
      if (m1_axi_wvalid) begin
        m1_axi_wready = (w_cnt == w_delay);
        if (w_cnt != w_delay) w_cnt++;
      end else begin
        m1_axi_wready = 1'b0; w_cnt = 0;
      end
      if (m1_axi_arvalid) begin
        m1_axi_arready = (ar_cnt == ar_delay);
        if (ar_cnt != ar_delay) ar_cnt++;
      end else begin
        m1_axi_arready = 1'b0; ar_cnt = 0;
      end
      if (m1_axi_bready) begin
        m1_axi_bvalid = (b_cnt == b_delay);
        m1_axi_bresp  = m1_axi_bvalid ? bresp_cfg : 2'b00;
        if (b_cnt != b_delay) b_cnt++;
      end else begin
        m1_axi_bvalid = 1'b0; m1_axi_bresp = 2'b00; b_cnt = 0;
      end
      if (m1_axi_rready) begin
        m1_axi_rvalid = (r_cnt == r_delay);
        m1_axi_rresp  = m1_axi_rvalid ? rresp_cfg : 2'b00;
        m1_axi_rdata  = m1_axi_rvalid ? rdata_cfg : '0;
        if (r_cnt != r_delay) r_cnt++;
      end else begin
        m1_axi_rvalid = 1'b0; m1_axi_rresp = 2'b00; m1_axi_rdata = '0; r_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(negedge m1_axi_aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one command, records its expected response, and returns in the first bus cycle.
  task automatic applyStimulus(input logic write, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [DW/8-1:0] strb);
    rsp_t e;
    int   n = 0;
    cmd_write = write; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    checkOutput("cmd_ready_wait", cmd_ready, 1);
    e.write = write;
    e.rdata = write ? '0 : rdata_cfg;
    e.resp  = write ? bresp_cfg : rresp_cfg;
    sb.push_back(e);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Waits for rsp_valid, holds rsp_ready low for 'hold' cycles, then consumes the response.
  task automatic waitResponse(input int hold);
    rsp_t e;
    int   n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    checkOutput("rsp_valid_wait", rsp_valid, 1);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL sb_pop: observed response with %0d queued, expected at least 1", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
        checkOutput("rsp_hold_valid", rsp_valid, 1);
        checkOutput("rsp_hold_resp", rsp_resp, e.resp);
        checkOutput("rsp_hold_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_hold_cmd_ready", cmd_ready, 0);
        tick();
      end
      rsp_ready = 1'b1;
      checkOutput("rsp_write", rsp_write, e.write);
      checkOutput("rsp_rdata", rsp_rdata, e.rdata);
      checkOutput("rsp_resp", rsp_resp, e.resp);
      tick();
      rsp_ready = 1'b0;
      checkOutput("rsp_done_cmd_ready", cmd_ready, 1);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0; timeout_clr = 1'b0;
    m1_axi_aresetn = 1'b0;
    tick();
    tick();
    checkOutput("reset_cmd_ready", cmd_ready, 0);
    checkOutput("reset_awvalid", m1_axi_awvalid, 0);
    checkOutput("reset_arvalid", m1_axi_arvalid, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_timeout", timeout, 0);
    checkOutput("reset_awaddr", m1_axi_awaddr, 0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 0);
    m1_axi_aresetn = 1'b1;
    tick();
    tick();
    checkOutput("post_reset_cmd_ready", cmd_ready, 1);

    $display("[TB] zero-wait write");
    applyStimulus(1'b1, 8'h03, 32'd39, 4'hF);
    checkOutput("zw_awvalid", m1_axi_awvalid, 1);
    checkOutput("zw_wvalid", m1_axi_wvalid, 1);
    checkOutput("zw_awready", m1_axi_awready, 1);
    checkOutput("zw_wready", m1_axi_wready, 1);
    checkOutput("zw_awaddr", m1_axi_awaddr, 8'h00);
    checkOutput("zw_wdata", m1_axi_wdata, 39);
    checkOutput("zw_wstrb", m1_axi_wstrb, 4'hF);
    tick();
    checkOutput("zw_c2_awvalid", m1_axi_awvalid, 0);
    checkOutput("zw_c2_bready", m1_axi_bready, 1);
    checkOutput("zw_c2_rsp_valid", rsp_valid, 0);
    tick();
    checkOutput("zw_c3_rsp_valid", rsp_valid, 1);
    waitResponse(0);

    $display("[TB] staggered write handshakes");
    aw_delay = 1; w_delay = 4;
    applyStimulus(1'b1, 8'h44, 32'hA5A5_0001, 4'h3);
    checkOutput("st_c1_awvalid", m1_axi_awvalid, 1);
    checkOutput("st_c1_wvalid", m1_axi_wvalid, 1);
    tick();
    checkOutput("st_c2_awready", m1_axi_awready, 1);
    tick();
    checkOutput("st_c3_awvalid", m1_axi_awvalid, 0);
    checkOutput("st_c3_wvalid", m1_axi_wvalid, 1);
    checkOutput("st_c3_wdata", m1_axi_wdata, 32'hA5A5_0001);
    checkOutput("st_c3_wstrb", m1_axi_wstrb, 4'h3);
    tick();
    tick();
    checkOutput("st_c5_wvalid", m1_axi_wvalid, 1);
    checkOutput("st_c5_wdata", m1_axi_wdata, 32'hA5A5_0001);
    checkOutput("st_c5_bready", m1_axi_bready, 0);
    tick();
    checkOutput("st_c6_bready", m1_axi_bready, 1);
    checkOutput("st_c6_wvalid", m1_axi_wvalid, 0);
    waitResponse(0);
    tick();
    checkOutput("st_single_rsp", rsp_valid, 0);
    checkOutput("st_sb_drained", 64'(sb.size()), 0);
    aw_delay = 0; w_delay = 0;

    $display("[TB] read with rvalid wait");
    r_delay = 2; rdata_cfg = 32'h4F; rresp_cfg = 2'b00;
    applyStimulus(1'b0, 8'h18, '0, '0);
    checkOutput("rd_arvalid", m1_axi_arvalid, 1);
    checkOutput("rd_araddr", m1_axi_araddr, 8'h18);
    checkOutput("rd_awvalid", m1_axi_awvalid, 0);
    tick();
    checkOutput("rd_rready", m1_axi_rready, 1);
    checkOutput("rd_arvalid_drop", m1_axi_arvalid, 0);
    tick();
    tick();
    checkOutput("rd_c4_rsp_valid", rsp_valid, 0);
    waitResponse(0);
    r_delay = 0;

    $display("[TB] error response with backpressure");
    bresp_cfg = 2'b10;
    applyStimulus(1'b1, 8'h0C, 32'h0000_1234, 4'hF);
    waitResponse(5);
    bresp_cfg = 2'b00;

    $display("[TB] watchdog");
    aw_delay = 20;
    applyStimulus(1'b1, 8'h20, 32'hDEAD_BEEF, 4'hF);
    checkOutput("wd_c1_timeout", timeout, 0);
    repeat (7) tick();
    checkOutput("wd_c8_timeout", timeout, 0);
    checkOutput("wd_c8_awvalid", m1_axi_awvalid, 1);
    tick();
    checkOutput("wd_c9_timeout", timeout, 1);
    checkOutput("wd_c9_awvalid", m1_axi_awvalid, 1);
    checkOutput("wd_c9_awaddr", m1_axi_awaddr, 8'h20);
    waitResponse(0);
    checkOutput("wd_sticky", timeout, 1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    checkOutput("wd_cleared", timeout, 0);
    aw_delay = 0;

    $display("[TB] reset during read data phase");
    r_delay = 40; rdata_cfg = 32'h77;
    applyStimulus(1'b0, 8'h30, '0, '0);
    tick();
    checkOutput("rst_rd_rready", m1_axi_rready, 1);
    repeat (10) tick();
    checkOutput("rst_rd_timeout_before", timeout, 1);
    m1_axi_aresetn = 1'b0;
    #1;
    checkOutput("rst_rready", m1_axi_rready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_araddr", m1_axi_araddr, 0);
    sb.delete();
    r_delay = 0; rdata_cfg = 32'h5A;
    tick();
    m1_axi_aresetn = 1'b1;
    tick();
    tick();
    checkOutput("rst_release_cmd_ready", cmd_ready, 1);
    applyStimulus(1'b0, 8'h07, '0, '0);
    checkOutput("rst_new_araddr", m1_axi_araddr, 8'h04);
    waitResponse(0);
    tick();
    checkOutput("rst_no_extra_rsp", rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
